ne16_job_dispatcher: RTL and testbench
======================================

NE16_JOB_DISPATCHER -- requirements
Module: ne16_job_dispatcher

Interface
REQ-001 Parameter ID, default ID_WIDTH: periph transaction id width.
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000: NE16 register file base address.
REQ-003 Parameter MAX_RETRY, default 16: maximum acquire retries before error.
REQ-004 Parameter RETRY_GAP, default 4: idle cycles between acquire retries.
REQ-005 The block SHALL have one clock and an asynchronous active-low reset: clk_i input 1, clock; rst_ni input 1, asynchronous active-low reset.
REQ-006 clear_i  input  1  synchronous soft clear.
REQ-007 cfg_valid_i  input  1  job-register beat valid.
REQ-008 cfg_ready_o  output  1  beat consumed.
REQ-009 cfg_offset_i  input  8  byte offset within the job register area (word aligned).
REQ-010 cfg_data_i  input  32  register value.
REQ-011 cfg_last_i  input  1  final beat of the job descriptor.
REQ-012 evt_i  input  1  NE16 end-of-job event for this core.
REQ-013 periph  hwpe_ctrl_intf_periph.master  req/gnt/add[31:0]/wen/be[3:0]/data[31:0]/id[ID-1:0]/r_valid/r_data[31:0]/r_id  register-port initiator.
REQ-014 job_done_o  output  1  one-cycle pulse on job completion.
REQ-015 job_id_o  output  8  id of the acquired or completed job.
REQ-016 error_o  output  1  one-cycle pulse on acquire exhaustion.
REQ-017 busy_o  output  1  high whenever state != IDLE.

Function
REQ-018 FSM states SHALL be IDLE, ACQ_REQ, ACQ_WAIT, RETRY, CFG, TRIG, WAIT_EVT, DRAIN.
REQ-019 IDLE -> ACQ_REQ when cfg_valid_i=1; no beat is consumed in IDLE.
REQ-020 ACQ_REQ SHALL issue a read (wen=1, be=4'hF) to BASE_ADDR+0x04; on gnt -> ACQ_WAIT.
REQ-021 periph.req with add/wen/be/data/id SHALL stay stable until gnt; at most one transaction outstanding.
REQ-022 ACQ_WAIT: on r_valid with r_id equal to the issued id, r_data[31]=0 -> latch r_data[7:0] into job_id_o, go to CFG; r_data[31]=1 -> RETRY.
REQ-023 RETRY SHALL wait RETRY_GAP cycles, increment the 16-bit retry counter, then ACQ_REQ; when the counter reaches MAX_RETRY -> pulse error_o and go to DRAIN.
REQ-024 CFG SHALL drive a write (wen=0, be=4'hF, data=cfg_data_i) to BASE_ADDR+0x20+cfg_offset_i while cfg_valid_i=1; cfg_ready_o = (state==CFG) & periph.gnt, combinationally.
REQ-025 In CFG, a consumed beat with cfg_last_i=1 SHALL move to TRIG; write responses (r_valid) SHALL be ignored.
REQ-026 In CFG, cfg_valid_i=0 SHALL deassert req; the FSM waits without timeout.
REQ-027 TRIG SHALL write 32'h0 to BASE_ADDR+0x00; on gnt -> WAIT_EVT.
REQ-028 WAIT_EVT: evt_i=1 -> job_done_o pulse for exactly one cycle with job_id_o unchanged, -> IDLE; evt_i in any other state SHALL be ignored.
REQ-029 DRAIN SHALL hold cfg_ready_o=1 without periph traffic, dropping beats until one with cfg_last_i=1 is consumed, then -> IDLE.
REQ-030 The retry counter SHALL be cleared when leaving ACQ_WAIT toward CFG and in IDLE.
REQ-031 The periph id SHALL be a free-running ID-bit counter incremented on every gnt; wrap-around is legal.
REQ-032 clear_i SHALL return the FSM to IDLE and zero the counters in the next cycle, overriding all other events, even with a transaction pending; a late r_valid SHALL then be ignored.

Reset
REQ-033 On rst_ni=0: state IDLE; periph.req, cfg_ready_o, job_done_o, error_o, busy_o = 0; job_id_o = 0; all counters = 0.
REQ-034 Reset mid-transaction SHALL abandon it silently, with no error pulse.

Structure
REQ-035 The FSM state enum and register offsets (0x00 trigger, 0x04 acquire, 0x20 job base) SHALL live in ne16_package.
REQ-036 One flat module; no sub-module required.

Verification
REQ-037 Acquire returns 0x00000003, 3 beats then evt_i after 50 cycles -> writes at BASE+0x20/0x24/0x28, trigger at BASE+0x00, job_done_o pulse with job_id_o=3.
REQ-038 Acquire returns 0x80000000 twice, then 0x00000001 -> two RETRY gaps of 4 cycles each, then normal configuration with job_id_o=1.
REQ-039 Acquire always returns bit31=1 with MAX_RETRY=16 -> error_o single pulse after the 16th retry; a 5-beat descriptor is drained with no periph writes.
REQ-040 gnt withheld for 7 cycles during CFG -> add/data stable, cfg_ready_o=0 until gnt; no beat lost or duplicated.
REQ-041 evt_i pulsed during CFG -> ignored; job_done_o only on the evt_i seen in WAIT_EVT.
REQ-042 clear_i in ACQ_WAIT, then r_valid returned -> IDLE next cycle, response ignored, busy_o=0.

Source files
------------

// File: rtl/ne16_package.sv
// ne16_package
//   Shared definitions for the NE16 job dispatcher:
//   - ne16_state_e   : dispatcher FSM state encoding
//   - NE16_REG_*     : NE16 register offsets relative to the register file base
//   - NE16_ACQ_BUSY  : bit of the acquire response that signals "no job slot free"
//   - ne16_job_addr  : absolute address of a job-register beat

package ne16_package;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ACQ_REQ  = 3'd1,
        ACQ_WAIT = 3'd2,
        RETRY    = 3'd3,
        CFG      = 3'd4,
        TRIG     = 3'd5,
        WAIT_EVT = 3'd6,
        DRAIN    = 3'd7
    } ne16_state_e;

    localparam logic [31:0] NE16_REG_TRIGGER  = 32'h0000_0000;
    localparam logic [31:0] NE16_REG_ACQUIRE  = 32'h0000_0004;
    localparam logic [31:0] NE16_REG_JOB_BASE = 32'h0000_0020;

    localparam int unsigned NE16_ACQ_BUSY = 31;

    function automatic logic [31:0] ne16_job_addr(input logic [31:0] base,
                                                  input logic [7:0]  offset);
        return base + NE16_REG_JOB_BASE + {24'h00_0000, offset};
    endfunction

endpackage

// File: rtl/ne16_job_dispatcher.sv
// ne16_job_dispatcher
//   Acquires an NE16 job slot over the register port, streams a job
//   descriptor into the job registers, triggers the job and waits for the
//   end-of-job event. A busy acquire is retried after a gap; when the retry
//   budget is exhausted the descriptor is drained and error_o pulses.
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   clear_i              synchronous soft clear (back to IDLE, counters zeroed)
//   cfg_valid_i/ready_o  job descriptor beat handshake
//   cfg_offset_i         byte offset of the beat inside the job register area
//   cfg_data_i           beat value
//   cfg_last_i           final beat of the descriptor
//   evt_i                NE16 end-of-job event
//   periph_*             register-port initiator (req/gnt, r_valid response)
//   job_done_o           one-cycle pulse when the job completes
//   job_id_o             id of the acquired / completed job
//   error_o              one-cycle pulse when acquire retries are exhausted
//   busy_o               high whenever the FSM is not IDLE
//   state_o              current FSM state (observability)
//
// Handshakes: a cfg beat transfers on a cycle with cfg_valid_i & cfg_ready_o;
// a periph request transfers on a cycle with periph_req_o & periph_gnt_i, and
// its address/data/id stay stable until then. The cfg source must hold its
// beat stable while cfg_valid_i is high and cfg_ready_o is low.

module ne16_job_dispatcher
    import ne16_package::*;
#(
    parameter int unsigned ID_WIDTH  = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_RETRY = 16,
    parameter int unsigned RETRY_GAP = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clear_i,

    input  logic                cfg_valid_i,
    output logic                cfg_ready_o,
    input  logic [7:0]          cfg_offset_i,
    input  logic [31:0]         cfg_data_i,
    input  logic                cfg_last_i,

    input  logic                evt_i,

    output logic                periph_req_o,
    input  logic                periph_gnt_i,
    output logic [31:0]         periph_add_o,
    output logic                periph_wen_o,
    output logic [3:0]          periph_be_o,
    output logic [31:0]         periph_data_o,
    output logic [ID_WIDTH-1:0] periph_id_o,
    input  logic                periph_r_valid_i,
    input  logic [31:0]         periph_r_data_i,
    input  logic [ID_WIDTH-1:0] periph_r_id_i,

    output logic                job_done_o,
    output logic [7:0]          job_id_o,
    output logic                error_o,
    output logic                busy_o,
    output ne16_state_e         state_o
);

    localparam logic [15:0]         MAX_RETRY_C = 16'(MAX_RETRY);
    localparam logic [15:0]         GAP_LAST_C  = 16'(RETRY_GAP - 1);
    localparam logic [ID_WIDTH-1:0] ID_ONE      = ID_WIDTH'(1);

    ne16_state_e         state_q, state_d;
    logic [15:0]         retry_q, retry_d;
    logic [15:0]         gap_q, gap_d;
    logic [ID_WIDTH-1:0] id_q, id_d;
    logic [ID_WIDTH-1:0] issued_id_q, issued_id_d;
    logic [7:0]          job_id_q, job_id_d;
    logic                job_done_q, job_done_d;
    logic                error_q, error_d;

    logic                req;
    logic [31:0]         add;
    logic                wen;
    logic [3:0]          be;
    logic [31:0]         wdata;
    logic                cfg_ready;

    // Only the busy flag and the job id are taken from acquire responses.
    logic unused_rdata;
    assign unused_rdata = ^periph_r_data_i[30:8];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            retry_q     <= '0;
            gap_q       <= '0;
            id_q        <= '0;
            issued_id_q <= '0;
            job_id_q    <= '0;
            job_done_q  <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            retry_q     <= retry_d;
            gap_q       <= gap_d;
            id_q        <= id_d;
            issued_id_q <= issued_id_d;
            job_id_q    <= job_id_d;
            job_done_q  <= job_done_d;
            error_q     <= error_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        retry_d     = retry_q;
        gap_d       = gap_q;
        id_d        = id_q;
        issued_id_d = issued_id_q;
        job_id_d    = job_id_q;
        job_done_d  = 1'b0;
        error_d     = 1'b0;

        req       = 1'b0;
        add       = 32'h0000_0000;
        wen       = 1'b1;
        be        = 4'h0;
        wdata     = 32'h0000_0000;
        cfg_ready = 1'b0;

        unique case (state_q)
            IDLE: begin
                retry_d = '0;
                gap_d   = '0;
                // The beat that wakes us up stays pending until CFG or DRAIN.
                if (cfg_valid_i) begin
                    state_d = ACQ_REQ;
                end
            end

            ACQ_REQ: begin
                req = 1'b1;
                add = BASE_ADDR + NE16_REG_ACQUIRE;
                wen = 1'b1;
                be  = 4'hF;
                if (periph_gnt_i) begin
                    issued_id_d = id_q;
                    state_d     = ACQ_WAIT;
                end
            end

            ACQ_WAIT: begin
                if (periph_r_valid_i && (periph_r_id_i == issued_id_q)) begin
                    if (periph_r_data_i[NE16_ACQ_BUSY]) begin
                        gap_d   = '0;
                        state_d = RETRY;
                    end else begin
                        job_id_d = periph_r_data_i[7:0];
                        retry_d  = '0;
                        state_d  = CFG;
                    end
                end
            end

            RETRY: begin
                if (gap_q == GAP_LAST_C) begin
                    gap_d   = '0;
                    retry_d = retry_q + 16'd1;
                    if ((retry_q + 16'd1) == MAX_RETRY_C) begin
                        error_d = 1'b1;
                        state_d = DRAIN;
                    end else begin
                        state_d = ACQ_REQ;
                    end
                end else begin
                    gap_d = gap_q + 16'd1;
                end
            end

            CFG: begin
                // Beats map 1:1 onto register writes; the grant is the beat's ready.
                req       = cfg_valid_i;
                add       = ne16_job_addr(BASE_ADDR, cfg_offset_i);
                wen       = 1'b0;
                be        = 4'hF;
                wdata     = cfg_data_i;
                cfg_ready = periph_gnt_i;
                if (cfg_valid_i && periph_gnt_i && cfg_last_i) begin
                    state_d = TRIG;
                end
            end

            TRIG: begin
                req   = 1'b1;
                add   = BASE_ADDR + NE16_REG_TRIGGER;
                wen   = 1'b0;
                be    = 4'hF;
                wdata = 32'h0000_0000;
                if (periph_gnt_i) begin
                    state_d = WAIT_EVT;
                end
            end

            WAIT_EVT: begin
                if (evt_i) begin
                    job_done_d = 1'b1;
                    state_d    = IDLE;
                end
            end

            DRAIN: begin
                cfg_ready = 1'b1;
                if (cfg_valid_i && cfg_last_i) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Clear wins over everything: no request or beat is accepted in the
        // clear cycle, so nothing half-transfers across it.
        if (clear_i) begin
            req       = 1'b0;
            cfg_ready = 1'b0;
        end

        if (req && periph_gnt_i) begin
            id_d = id_q + ID_ONE;
        end

        if (clear_i) begin
            state_d    = IDLE;
            retry_d    = '0;
            gap_d      = '0;
            id_d       = '0;
            job_done_d = 1'b0;
            error_d    = 1'b0;
        end
    end

    assign periph_req_o  = req;
    assign periph_add_o  = add;
    assign periph_wen_o  = wen;
    assign periph_be_o   = be;
    assign periph_data_o = wdata;
    assign periph_id_o   = id_q;

    assign cfg_ready_o = cfg_ready;
    assign job_done_o  = job_done_q;
    assign job_id_o    = job_id_q;
    assign error_o     = error_q;
    assign busy_o      = (state_q != IDLE);
    assign state_o     = state_q;

endmodule

// File: tb/tb_ne16_job_dispatcher.sv
// tb_ne16_job_dispatcher
//   Directed bench for ne16_job_dispatcher. Stimulus pushes the expected
//   register-port transactions and job events into queues; a monitor pops and
//   compares them whenever the DUT presents a granted transaction or a pulse.

module tb_ne16_job_dispatcher;
    import ne16_package::*;

    localparam int unsigned ID_W  = 4;
    localparam logic [31:0] BASE  = 32'h1A10_0000;
    localparam int unsigned MAX_R = 16;
    localparam int unsigned GAP   = 4;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- DUT signals ----------------
    logic            clear;
    logic            cfg_valid;
    logic            cfg_ready;
    logic [7:0]      cfg_offset;
    logic [31:0]     cfg_data;
    logic            cfg_last;
    logic            evt;
    logic            req;
    logic            gnt;
    logic [31:0]     add;
    logic            wen;
    logic [3:0]      be;
    logic [31:0]     wdata;
    logic [ID_W-1:0] pid;
    logic            r_valid;
    logic [31:0]     r_data;
    logic [ID_W-1:0] r_id;
    logic            job_done;
    logic [7:0]      job_id;
    logic            err;
    logic            busy;
    ne16_state_e     state;

    logic            withhold;
    logic            hold_resp;

    assign gnt = req & ~withhold;

    ne16_job_dispatcher #(
        .ID_WIDTH (ID_W),
        .BASE_ADDR(BASE),
        .MAX_RETRY(MAX_R),
        .RETRY_GAP(GAP)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .clear_i         (clear),
        .cfg_valid_i     (cfg_valid),
        .cfg_ready_o     (cfg_ready),
        .cfg_offset_i    (cfg_offset),
        .cfg_data_i      (cfg_data),
        .cfg_last_i      (cfg_last),
        .evt_i           (evt),
        .periph_req_o    (req),
        .periph_gnt_i    (gnt),
        .periph_add_o    (add),
        .periph_wen_o    (wen),
        .periph_be_o     (be),
        .periph_data_o   (wdata),
        .periph_id_o     (pid),
        .periph_r_valid_i(r_valid),
        .periph_r_data_i (r_data),
        .periph_r_id_i   (r_id),
        .job_done_o      (job_done),
        .job_id_o        (job_id),
        .error_o         (err),
        .busy_o          (busy),
        .state_o         (state)
    );

    // ---------------- scoreboard state ----------------
    logic [68:0]     exp_q[$];      // {wen, be, add, data}
    logic [8:0]      exp_evt_q[$];  // {is_error, job_id}
    logic [31:0]     resp_q[$];     // acquire read responses, in order
    logic [ID_W:0]   pend_q[$];     // {wen, id} of granted requests
    logic [ID_W-1:0] exp_id;
    int              checks;
    int              errors;
    int              retry_run;
    int              retry_gaps;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic logic [68:0] txn(input logic w, input logic [31:0] a, input logic [31:0] d);
        return {w, 4'hF, a, d};
    endfunction

    task automatic exp_read();
        exp_q.push_back(txn(1'b1, BASE + 32'h0000_0004, 32'h0));
    endtask

    task automatic exp_write(input logic [7:0] off, input logic [31:0] d);
        exp_q.push_back(txn(1'b0, BASE + 32'h0000_0020 + {24'h0, off}, d));
    endtask

    task automatic exp_trig();
        exp_q.push_back(txn(1'b0, BASE, 32'h0));
    endtask

    // ---------------- register-port responder ----------------
    initial begin
        logic [ID_W:0] p;
        r_valid = 1'b0;
        r_data  = 32'h0;
        r_id    = '0;
        forever begin
            @(negedge clk);
            if (rst_n && req && gnt) pend_q.push_back({wen, pid});
            @(posedge clk);
            #1;
            r_valid = 1'b0;
            if (!hold_resp && pend_q.size() > 0) begin
                p       = pend_q.pop_front();
                r_valid = 1'b1;
                r_id    = p[ID_W-1:0];
                r_data  = 32'h0;
                if (p[ID_W] && resp_q.size() > 0) r_data = resp_q.pop_front();
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        logic [8:0] e;
        retry_run  = 0;
        retry_gaps = 0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (req && gnt) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_txn: got %0h, required none", {wen, be, add, wdata});
                    end else begin
                        check("periph_txn", 96'({wen, be, add, wdata}), 96'(exp_q.pop_front()));
                    end
                    check("periph_id", 96'(pid), 96'(exp_id));
                    exp_id = exp_id + 1'b1;
                end
                if (job_done || err) begin
                    if (exp_evt_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_pulse: got done=%0b err=%0b, required none", job_done, err);
                    end else begin
                        e = exp_evt_q.pop_front();
                        if (err) check("error_pulse", 96'({err, job_done}), 96'({e[8], ~e[8]}));
                        else     check("job_done", 96'({err, job_id}), 96'(e));
                    end
                end
                if (state == RETRY) begin
                    retry_run++;
                end else if (retry_run != 0) begin
                    check("retry_gap_len", 96'(retry_run), 96'(GAP));
                    retry_gaps++;
                    retry_run = 0;
                end
            end
        end
    end

    // ---------------- driver tasks (called at posedge + 1) ----------------
    task automatic wait_state(input ne16_state_e s, input int budget, input string name);
        int n = 0;
        while (state != s && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, 96'(state), 96'(s));
    endtask

    task automatic send_beat(input logic [7:0] off, input logic [31:0] d, input logic last);
        int n = 0;
        cfg_valid  = 1'b1;
        cfg_offset = off;
        cfg_data   = d;
        cfg_last   = last;
        forever begin
            @(negedge clk);
            if (cfg_ready) break;
            n++;
            if (n > 2000) begin
                checks++;
                errors++;
                $display("FAIL beat_timeout: got no ready, required ready within 2000 cycles");
                break;
            end
        end
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
    endtask

    task automatic pulse_evt(input int delay);
        repeat (delay) @(posedge clk);
        #1;
        evt = 1'b1;
        @(posedge clk);
        #1;
        evt = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    int gaps_before;

    initial begin
        checks     = 0;
        errors     = 0;
        exp_id     = '0;
        rst_n      = 1'b0;
        clear      = 1'b0;
        cfg_valid  = 1'b0;
        cfg_offset = 8'h00;
        cfg_data   = 32'h0;
        cfg_last   = 1'b0;
        evt        = 1'b0;
        withhold   = 1'b0;
        hold_resp  = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", 96'({req, cfg_ready, job_done, err, busy}), 96'(0));
        check("reset_job_id", 96'(job_id), 96'(0));
        check("reset_state", 96'(state), 96'(IDLE));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Job id 3, three beats, event after 50 cycles
        resp_q.push_back(32'h0000_0003);
        exp_read();
        exp_write(8'h00, 32'hA000_0000);
        exp_write(8'h04, 32'hA000_0004);
        exp_write(8'h08, 32'hA000_0008);
        exp_trig();
        exp_evt_q.push_back({1'b0, 8'h03});
        send_beat(8'h00, 32'hA000_0000, 1'b0);
        send_beat(8'h04, 32'hA000_0004, 1'b0);
        send_beat(8'h08, 32'hA000_0008, 1'b1);
        wait_state(WAIT_EVT, 20, "t1_reach_wait_evt");
        check("t1_busy_in_wait", 96'(busy), 96'(1));
        pulse_evt(50);
        wait_state(IDLE, 5, "t1_back_idle");
        @(negedge clk);
        check("t1_job_id", 96'(job_id), 96'(8'h03));

        // Two busy acquires, then job id 1
        @(posedge clk);
        #1;
        gaps_before = retry_gaps;
        resp_q.push_back(32'h8000_0000);
        resp_q.push_back(32'h8000_0000);
        resp_q.push_back(32'h0000_0001);
        repeat (3) exp_read();
        exp_write(8'h10, 32'h1111_0010);
        exp_write(8'h14, 32'h1111_0014);
        exp_trig();
        exp_evt_q.push_back({1'b0, 8'h01});
        send_beat(8'h10, 32'h1111_0010, 1'b0);
        send_beat(8'h14, 32'h1111_0014, 1'b1);
        wait_state(WAIT_EVT, 20, "t2_reach_wait_evt");
        pulse_evt(5);
        wait_state(IDLE, 5, "t2_back_idle");
        check("t2_retry_gaps", 96'(retry_gaps - gaps_before), 96'(2));

        // Acquire always busy: error after the retry budget, descriptor drained
        gaps_before = retry_gaps;
        for (int i = 0; i < int'(MAX_R); i++) begin
            resp_q.push_back(32'h8000_00FF);
            exp_read();
        end
        exp_evt_q.push_back({1'b1, 8'h00});
        for (int i = 0; i < 5; i++) begin
            send_beat(8'(4 * i), 32'hD000_0000 + 32'(i), (i == 4));
        end
        wait_state(IDLE, 10, "t3_back_idle");
        check("t3_no_periph_left", 96'(exp_q.size()), 96'(0));
        check("t3_retry_gaps", 96'(retry_gaps - gaps_before), 96'(MAX_R));
        check("t3_job_id_kept", 96'(job_id), 96'(8'h01));

        // Grant withheld for 7 cycles on the first job-register write
        resp_q.push_back(32'h0000_0005);
        exp_read();
        exp_write(8'h00, 32'h5555_0000);
        exp_write(8'h04, 32'h5555_0004);
        exp_write(8'h08, 32'h5555_0008);
        exp_trig();
        exp_evt_q.push_back({1'b0, 8'h05});
        fork
            begin
                send_beat(8'h00, 32'h5555_0000, 1'b0);
                send_beat(8'h04, 32'h5555_0004, 1'b0);
                send_beat(8'h08, 32'h5555_0008, 1'b1);
            end
            begin
                wait_state(CFG, 40, "t4_reach_cfg");
                withhold = 1'b1;
                repeat (7) begin
                    @(negedge clk);
                    check("t4_hold_ready", 96'({req, cfg_ready}), 96'(2'b10));
                    check("t4_hold_add_data", 96'({add, wdata}), 96'({BASE + 32'h20, 32'h5555_0000}));
                end
                @(posedge clk);
                #1;
                withhold = 1'b0;
            end
        join
        wait_state(WAIT_EVT, 20, "t4_reach_wait_evt");
        pulse_evt(3);
        wait_state(IDLE, 5, "t4_back_idle");

        // Event during CFG is ignored; only the one in WAIT_EVT completes
        resp_q.push_back(32'h0000_0007);
        exp_read();
        exp_write(8'h40, 32'h7777_0040);
        exp_write(8'h44, 32'h7777_0044);
        exp_trig();
        exp_evt_q.push_back({1'b0, 8'h07});
        fork
            begin
                send_beat(8'h40, 32'h7777_0040, 1'b0);
                send_beat(8'h44, 32'h7777_0044, 1'b1);
            end
            begin
                wait_state(CFG, 40, "t5_reach_cfg");
                evt = 1'b1;
                @(negedge clk);
                check("t5_evt_seen_in_cfg", 96'(state), 96'(CFG));
                @(posedge clk);
                #1;
                evt = 1'b0;
            end
        join
        wait_state(WAIT_EVT, 20, "t5_reach_wait_evt");
        pulse_evt(4);
        wait_state(IDLE, 5, "t5_back_idle");

        // Clear while the acquire read is outstanding; its late response is ignored
        hold_resp = 1'b1;
        resp_q.push_back(32'h0000_0009);
        exp_read();
        cfg_valid  = 1'b1;
        cfg_offset = 8'h00;
        cfg_data   = 32'h9999_0000;
        cfg_last   = 1'b1;
        wait_state(ACQ_WAIT, 10, "t6_reach_acq_wait");
        clear     = 1'b1;
        cfg_valid = 1'b0;
        exp_id    = '0;
        @(posedge clk);
        #1;
        clear = 1'b0;
        @(negedge clk);
        check("t6_idle_after_clear", 96'({state, busy, req}), 96'({IDLE, 1'b0, 1'b0}));
        @(posedge clk);
        #1;
        hold_resp = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("t6_late_resp_ignored", 96'({state, job_id}), 96'({IDLE, 8'h07}));

        // Normal job after the clear
        resp_q.push_back(32'h0000_000B);
        exp_read();
        exp_write(8'h3C, 32'hBBBB_003C);
        exp_trig();
        exp_evt_q.push_back({1'b0, 8'h0B});
        send_beat(8'h3C, 32'hBBBB_003C, 1'b1);
        wait_state(WAIT_EVT, 20, "t7_reach_wait_evt");
        pulse_evt(2);
        wait_state(IDLE, 5, "t7_back_idle");

        repeat (5) @(posedge clk);
        #1;
        check("final_exp_q_empty", 96'(exp_q.size()), 96'(0));
        check("final_evt_q_empty", 96'(exp_evt_q.size()), 96'(0));
        check("final_busy", 96'(busy), 96'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Time limit so the run always terminates.
    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog: got no completion, required finish before time limit");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
